// File: rtl/crypto_pkg.sv
// Shared constants and types for the decryption datapath and its plaintext collector.
package crypto_pkg;

    localparam logic [7:0] NULL_CHAR        = 8'h00;
    localparam logic [7:0] LOWERCASE_A_CHAR = 8'h61;
    localparam logic [7:0] LOWERCASE_Z_CHAR = 8'h7A;

    localparam logic [1:0] MODE_DECRYPT = 2'b11;
    localparam int unsigned P = 227;
    localparam int unsigned Q = 225;

    typedef enum logic [1:0] {
        RUN,
        HALT,
        FLUSH
    } collector_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a separately held occupancy count and a synchronous flush.
module sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic                       rd_en,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/plaintext_collector.sv
// Buffers decrypted plaintext for the consumer, aligns and latches decryption
// error flags, and halts intake after a secret-key error until cleared.
module plaintext_collector
    import crypto_pkg::*;
#(
    parameter int unsigned DEPTH           = 16,
    parameter int unsigned CNT_W           = 8,
    parameter bit          HALT_ON_KEY_ERR = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 in_plaintext,
    input  logic                       in_valid,
    input  logic                       in_err_ctxt,
    input  logic                       in_err_seckey,
    input  logic                       clr_err,
    output logic [7:0]                 out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic [CNT_W-1:0]           err_ctxt_cnt,
    output logic                       err_key,
    output logic                       halted
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    collector_state_t state;
    logic             err_ctxt_d;
    logic             err_key_d;
    logic             push_req;
    logic             push_acc;
    logic             pop;
    logic             flush;
    logic [7:0]       fifo_dout;

    assign push_req  = in_valid && (state == RUN);
    assign pop       = out_valid && out_ready;
    assign push_acc  = push_req && (!full || pop);
    assign flush     = (state == FLUSH);
    assign out_valid = !empty && (state != FLUSH);
    assign out_data  = empty ? NULL_CHAR : fifo_dout;
    assign halted    = (state == HALT);

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .wr_en (push_acc),
        .rd_en (pop),
        .din   (in_plaintext),
        .dout  (fifo_dout),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Error events override a same-cycle clr_err so no event is ever lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            err_ctxt_d   <= 1'b0;
            err_key_d    <= 1'b0;
            overflow     <= 1'b0;
            err_ctxt_cnt <= '0;
            err_key      <= 1'b0;
        end else begin
            err_ctxt_d <= in_err_ctxt;
            err_key_d  <= in_err_seckey;

            if (push_req && full && !pop) overflow <= 1'b1;
            else if (clr_err)             overflow <= 1'b0;

            if (err_ctxt_d) begin
                if (clr_err)                     err_ctxt_cnt <= CNT_W'(1);
                else if (err_ctxt_cnt != CNT_MAX) err_ctxt_cnt <= err_ctxt_cnt + CNT_W'(1);
            end else if (clr_err) begin
                err_ctxt_cnt <= '0;
            end

            if (err_key_d)    err_key <= 1'b1;
            else if (clr_err) err_key <= 1'b0;

            case (state)
                RUN:     if (err_key_d && HALT_ON_KEY_ERR) state <= HALT;
                HALT:    if (clr_err) state <= FLUSH;
                FLUSH:   state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_plaintext_collector.sv
// Directed bench for plaintext_collector: table-driven FIFO vectors plus
// hand-written overflow, error-counter, key-halt and reset sequences.
module tb_plaintext_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_plaintext;
    logic       in_valid;
    logic       in_err_ctxt;
    logic       in_err_seckey;
    logic       clr_err;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic [1:0] err_ctxt_cnt;
    logic       err_key;
    logic       halted;

    int checks = 0;
    int errors = 0;

    plaintext_collector #(
        .DEPTH           (16),
        .CNT_W           (2),
        .HALT_ON_KEY_ERR (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_plaintext  (in_plaintext),
        .in_valid      (in_valid),
        .in_err_ctxt   (in_err_ctxt),
        .in_err_seckey (in_err_seckey),
        .clr_err       (clr_err),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .overflow      (overflow),
        .err_ctxt_cnt  (err_ctxt_cnt),
        .err_key       (err_key),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       r;
        logic       exp_ov;
        logic [7:0] exp_od;
        int         exp_cnt;
        logic       exp_empty;
    } vec_t;

    vec_t tbl [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        in_valid      = 1'b0;
        in_plaintext  = 8'h00;
        in_err_ctxt   = 1'b0;
        in_err_seckey = 1'b0;
        clr_err       = 1'b0;
        out_ready     = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " out_data"},     int'(out_data), 0);
        chk({tag, " out_valid"},    int'(out_valid), 0);
        chk({tag, " count"},        int'(count), 0);
        chk({tag, " empty"},        int'(empty), 1);
        chk({tag, " full"},         int'(full), 0);
        chk({tag, " overflow"},     int'(overflow), 0);
        chk({tag, " err_ctxt_cnt"}, int'(err_ctxt_cnt), 0);
        chk({tag, " err_key"},      int'(err_key), 0);
        chk({tag, " halted"},       int'(halted), 0);
    endtask

    task automatic ctxt_event();
        in_err_ctxt = 1'b1;
        tick();
        in_err_ctxt = 1'b0;
        tick();
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'h63, 1'b0, 1'b1, 8'h63, 1, 1'b0};
        tbl[1] = '{1'b1, 8'h69, 1'b0, 1'b1, 8'h63, 2, 1'b0};
        tbl[2] = '{1'b1, 8'h61, 1'b0, 1'b1, 8'h63, 3, 1'b0};
        tbl[3] = '{1'b1, 8'h6F, 1'b0, 1'b1, 8'h63, 4, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h69, 3, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h61, 2, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h6F, 1, 1'b0};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 1'b1};

        idle();
        rst = 1'b1;
        tick();
        tick();
        check_reset_values("reset");
        rst = 1'b0;

        // "ciao" buffered then drained in order.
        for (int i = 0; i < 8; i++) begin
            in_valid     = tbl[i].v;
            in_plaintext = tbl[i].d;
            out_ready    = tbl[i].r;
            tick();
            chk($sformatf("vec%0d out_valid", i), int'(out_valid), int'(tbl[i].exp_ov));
            chk($sformatf("vec%0d out_data", i),  int'(out_data),  int'(tbl[i].exp_od));
            chk($sformatf("vec%0d count", i),     int'(count),     tbl[i].exp_cnt);
            chk($sformatf("vec%0d empty", i),     int'(empty),     int'(tbl[i].exp_empty));
        end
        idle();

        // Fill to 16, then push while full without and with a same-cycle pop.
        for (int i = 0; i < 16; i++) begin
            in_valid     = 1'b1;
            in_plaintext = 8'h61 + 8'(i);
            tick();
        end
        chk("fill count", int'(count), 16);
        chk("fill full", int'(full), 1);
        chk("fill head", int'(out_data), 8'h61);
        in_plaintext = 8'h7A;
        tick();
        chk("drop overflow", int'(overflow), 1);
        chk("drop count", int'(count), 16);
        idle();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr overflow", int'(overflow), 0);
        in_valid     = 1'b1;
        in_plaintext = 8'h7A;
        out_ready    = 1'b1;
        tick();
        chk("pushpop count", int'(count), 16);
        chk("pushpop overflow", int'(overflow), 0);
        chk("pushpop head", int'(out_data), 8'h62);
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d data", i), int'(out_data), (i < 15) ? (8'h62 + i) : 8'h7A);
            tick();
        end
        chk("drain empty", int'(empty), 1);
        idle();

        // Saturating ciphertext-error counter.
        ctxt_event();
        chk("ctxt cnt1", int'(err_ctxt_cnt), 1);
        ctxt_event();
        ctxt_event();
        chk("ctxt cnt3", int'(err_ctxt_cnt), 3);
        ctxt_event();
        chk("ctxt saturate", int'(err_ctxt_cnt), 3);
        chk("ctxt err_key", int'(err_key), 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("ctxt clr", int'(err_ctxt_cnt), 0);

        // clr_err coinciding with an aligned event: event wins.
        ctxt_event();
        ctxt_event();
        chk("ctxt pre-clr", int'(err_ctxt_cnt), 2);
        in_err_ctxt = 1'b1;
        tick();
        in_err_ctxt = 1'b0;
        clr_err     = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr+event cnt", int'(err_ctxt_cnt), 1);
        chk("clr+event key", int'(err_key), 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;

        // Key error with 5 bytes buffered: halt, drain, flush.
        for (int i = 0; i < 5; i++) begin
            in_valid     = 1'b1;
            in_plaintext = 8'h61 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        chk("key pre count", int'(count), 5);
        in_err_seckey = 1'b1;
        tick();
        in_err_seckey = 1'b0;
        chk("key aligned halted", int'(halted), 0);
        tick();
        chk("key err_key", int'(err_key), 1);
        chk("key halted", int'(halted), 1);
        in_valid     = 1'b1;
        in_plaintext = 8'h7A;
        tick();
        tick();
        in_valid = 1'b0;
        chk("halt count", int'(count), 5);
        chk("halt overflow", int'(overflow), 0);
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        chk("halt pop count", int'(count), 3);
        chk("halt pop head", int'(out_data), 8'h63);
        chk("halt still", int'(halted), 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("flush halted", int'(halted), 0);
        chk("flush out_valid", int'(out_valid), 0);
        chk("flush err_key", int'(err_key), 0);
        tick();
        chk("run count", int'(count), 0);
        chk("run empty", int'(empty), 1);
        in_valid     = 1'b1;
        in_plaintext = 8'h71;
        tick();
        in_valid = 1'b0;
        chk("run accepts", int'(count), 1);
        chk("run data", int'(out_data), 8'h71);

        // Reset mid-operation with 7 buffered.
        for (int i = 0; i < 6; i++) begin
            in_valid     = 1'b1;
            in_plaintext = 8'h41 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        ctxt_event();
        chk("pre-rst count", int'(count), 7);
        chk("pre-rst out_valid", int'(out_valid), 1);
        chk("pre-rst cnt", int'(err_ctxt_cnt), 1);
        rst       = 1'b1;
        out_ready = 1'b1;
        tick();
        rst       = 1'b0;
        out_ready = 1'b0;
        check_reset_values("midrst");
        in_valid     = 1'b1;
        in_plaintext = 8'h62;
        tick();
        in_valid = 1'b0;
        chk("post-rst data", int'(out_data), 8'h62);
        chk("post-rst valid", int'(out_valid), 1);
        chk("post-rst count", int'(count), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
